// File: rtl/bp_pkg.sv
// Shared types for the branch resolve controller: tracking entry, FSM states, PC width.
// Latency: n/a (types only).
// Backpressure: n/a.
package bp_pkg;

    localparam int XLEN = 64;

    // One in-flight prediction: branch PC and the next PC fetch assumed.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } track_entry_t;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } bp_state_e;

    // Fall-through PC of a branch; 64-bit wrap-around is intended.
    function automatic logic [XLEN-1:0] seq_next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/bp_track_fifo.sv
// Prediction tracking queue: DEPTH entries, head visible combinationally.
// Latency: push visible at head the cycle after the write; pop/clear take effect at the edge.
// Backpressure: caller must gate push on !o_full (or on a same-cycle pop); clear beats push/pop.
//
// Ports: clk/reset (sync, active-high), i_push/i_wdata write at tail, i_pop retires head,
//        i_clear empties the queue, o_rdata = head entry, o_full/o_empty status.
module bp_track_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  track_entry_t i_wdata,
    input  logic         i_pop,
    input  logic         i_clear,
    output track_entry_t o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    track_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // A pop frees the head slot in the same edge, so a push into a full queue is legal then.
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_do_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_do_push && !reset && !i_clear) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_head];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Tracks in-flight branch predictions, checks them at resolve, trains the predictor and flushes on mispredict.
// Latency: resolve -> upd/flush outputs registered one cycle later; RECOVER lasts FLUSH_CYCLES from the flush cycle.
// Backpressure: pred_ready low when queue full (unless popping this cycle), during RECOVER and during reset.
//
// Ports: clk, reset (sync active-high); pred_valid/pred_ready/pred_pc/pred_target from fetch;
//        resolve_valid/resolve_pc from execute; flush/redirect_pc to fetch;
//        upd_valid/upd_pc/upd_taken to the predictor; protocol_err sticky.
// Optional: define BRANCH_RESOLVE_STATS_EN to add stat_branches / stat_mispredicts (32-bit, saturating).
module branch_resolve_ctrl
    import bp_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pred_valid,
    output logic            pred_ready,
    input  logic [XLEN-1:0] pred_pc,
    input  logic [XLEN-1:0] pred_target,
    input  logic            resolve_valid,
    input  logic [XLEN-1:0] resolve_pc,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic            upd_valid,
    output logic [XLEN-1:0] upd_pc,
    output logic            upd_taken,
    output logic            protocol_err
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    bp_state_e       r_state;
    logic [3:0]      r_rec_cnt;
    logic            r_flush;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_upd_valid;
    logic [XLEN-1:0] r_upd_pc;
    logic            r_upd_taken;
    logic            r_protocol_err;

    track_entry_t w_head;
    track_entry_t w_wdata;
    logic         w_full;
    logic         w_empty;
    logic         w_run;
    logic         w_pop;
    logic         w_mispredict;
    logic         w_taken;
    logic         w_ready;
    logic         w_push;
    logic         w_err_evt;

    assign w_run        = (r_state == ST_RUN);
    assign w_pop        = w_run && resolve_valid && !w_empty;
    assign w_mispredict = w_pop && (resolve_pc != w_head.target);
    assign w_taken      = (resolve_pc != seq_next_pc(w_head.pc));
    assign w_ready      = !reset && w_run && (!w_full || w_pop);
    // A push alongside a mispredict is on the wrong path: handshake completes, entry is dropped.
    assign w_push       = pred_valid && w_ready && !w_mispredict;
    assign w_err_evt    = w_run && resolve_valid && w_empty;

    assign w_wdata.pc     = pred_pc;
    assign w_wdata.target = pred_target;

    bp_track_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .i_clear (w_mispredict),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_RUN;
            r_rec_cnt      <= '0;
            r_flush        <= 1'b0;
            r_redirect_pc  <= '0;
            r_upd_valid    <= 1'b0;
            r_upd_pc       <= '0;
            r_upd_taken    <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_flush     <= 1'b0;
            r_upd_valid <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_err_evt) begin
                        r_protocol_err <= 1'b1;
                    end
                    if (w_pop) begin
                        r_upd_valid <= 1'b1;
                        r_upd_pc    <= w_head.pc;
                        r_upd_taken <= w_taken;
                    end
                    if (w_mispredict) begin
                        r_flush       <= 1'b1;
                        r_redirect_pc <= resolve_pc;
                        r_state       <= ST_RECOVER;
                        // The flush cycle itself is the first RECOVER cycle.
                        r_rec_cnt     <= 4'(FLUSH_CYCLES - 1);
                    end
                end
                ST_RECOVER: begin
                    if (r_rec_cnt == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_rec_cnt <= r_rec_cnt - 4'd1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_pop && (r_stat_branches != '1)) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (w_mispredict && (r_stat_mispredicts != '1)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

    assign pred_ready   = w_ready;
    assign flush        = r_flush;
    assign redirect_pc  = r_redirect_pc;
    assign upd_valid    = r_upd_valid;
    assign upd_pc       = r_upd_pc;
    assign upd_taken    = r_upd_taken;
    assign protocol_err = r_protocol_err;

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of in-flight prediction tracking entries (power of two, 2..16).
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of fetch-stall cycles after a mispredict (1..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port pred_valid, input, 1, meaning fetch offers a prediction this cycle.
REQ-006 The block SHALL have port pred_ready, output, 1, meaning the prediction is accepted when pred_valid is also high.
REQ-007 The block SHALL have ports pred_pc (input, 64) and pred_target (input, 64), meaning the branch PC and the predicted next PC.
REQ-008 The block SHALL have ports resolve_valid (input, 1) and resolve_pc (input, 64), meaning execute has resolved the oldest branch to the correct next PC.
REQ-009 The block SHALL have ports flush (output, 1) and redirect_pc (output, 64), meaning a pipeline flush pulse and the correct fetch PC.
REQ-010 The block SHALL have ports upd_valid (output, 1), upd_pc (output, 64) and upd_taken (output, 1), meaning the predictor training strobe, the branch PC and the actual outcome.
REQ-011 The block SHALL have port protocol_err, output, 1, meaning a sticky error flag.

Function
REQ-012 Each push SHALL occur when pred_valid and pred_ready are both high, writing {pred_pc, pred_target} at the tail.
REQ-013 pred_ready SHALL be high only in state RUN when the queue is not full, or when it is full and a pop occurs in the same cycle.
REQ-014 Each pop SHALL occur when resolve_valid is high in RUN with the queue non-empty, and SHALL compare the head entry against resolve_pc.
REQ-015 The actual outcome SHALL be taken = (resolve_pc != head.pc + 4), using 64-bit wrap-around addition.
REQ-016 A mispredict SHALL be defined as resolve_pc != head.target, compared over all 64 bits.
REQ-017 Every pop SHALL drive upd_valid=1, upd_pc=head.pc and upd_taken=taken, registered, in the cycle after the pop.
REQ-018 On a mispredict pop, the following cycle SHALL drive flush=1 for exactly one cycle with redirect_pc=resolve_pc; the queue SHALL be emptied and the state SHALL change to RECOVER.
REQ-019 A push in the same cycle as a mispredict pop SHALL be discarded as wrong-path.
REQ-020 The state machine SHALL have two states, RUN and RECOVER. RECOVER SHALL last FLUSH_CYCLES cycles, counted from the flush cycle, and then return to RUN.
REQ-021 In RECOVER, pred_ready SHALL be 0, and resolve_valid SHALL be ignored with no error raised.
REQ-022 resolve_valid in RUN with an empty queue SHALL set protocol_err, which stays set until reset; no pop or update occurs.
REQ-023 A correct-prediction pop SHALL leave flush=0; redirect_pc SHALL hold its last value.
REQ-024 Head and tail pointers SHALL wrap modulo DEPTH, and the occupancy count SHALL distinguish full from empty.

Reset
REQ-025 While reset is high at a clock edge, the block SHALL set state=RUN, empty the queue, clear the RECOVER counter, and drive flush=0, upd_valid=0, upd_pc=0, upd_taken=0, redirect_pc=0 and protocol_err=0.
REQ-026 Reset SHALL take priority over all other events, including a flush or RECOVER in progress.
REQ-027 pred_ready SHALL be 0 during reset and SHALL be 1 in the first cycle after reset.

Configuration
REQ-028 When macro BRANCH_RESOLVE_STATS_EN is defined, the block SHALL add two 32-bit saturating outputs: stat_branches (counts pops) and stat_mispredicts (counts mispredict pops). Both SHALL be cleared by reset.
REQ-029 When BRANCH_RESOLVE_STATS_EN is undefined, those ports and counters SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-030 Shared package bp_pkg SHALL hold the tracking-entry struct {pc, target}, the RUN/RECOVER state enum and the XLEN=64 constant.
REQ-031 The queue SHALL be the sub-module bp_track_fifo, which has synchronous push/pop/clear and full/empty outputs. The state machine and comparison logic SHALL be in branch_resolve_ctrl.

Verification
REQ-032 The bench SHALL cover this scenario: push {pc=0x100, target=0x104}, then resolve_pc=0x104 -> next cycle upd_valid=1, upd_taken=0, flush=0.
REQ-033 The bench SHALL cover this scenario: push {0x200, 0x204}, then resolve_pc=0x280 -> next cycle flush=1, redirect_pc=0x280, upd_taken=1; pred_ready=0 for 2 cycles, then 1.
REQ-034 The bench SHALL cover this scenario: 4 pushes with no resolve -> pred_ready=0; push and resolve in the same cycle -> push accepted and count stays at 4.
REQ-035 The bench SHALL cover this scenario: resolve_valid with an empty queue -> protocol_err=1 and it stays set; reset -> protocol_err=0.
REQ-036 The bench SHALL cover this scenario: a mispredict coincident with pred_valid -> the pushed entry is dropped and the queue is empty after the flush.
REQ-037 The bench SHALL cover this scenario: with BRANCH_RESOLVE_STATS_EN defined, 3 pops including 1 mispredict -> stat_branches=3 and stat_mispredicts=1.
